// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: controller state encoding.
package sub_pkg;

  localparam logic [1:0] ST_IDLE_ENC = 2'b00;
  localparam logic [1:0] ST_RUN_ENC  = 2'b01;
  localparam logic [1:0] ST_DONE_ENC = 2'b10;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE_ENC,
    RUN  = ST_RUN_ENC,
    DONE = ST_DONE_ENC
  } state_t;

endpackage

// File: rtl/serial_subtractor_ctrl_cell.sv
// Combinational 1-bit full-subtract cell: d = x - y - bin, bout = borrow out.
module serial_sub_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial unsigned subtractor controller: one subtract cell run LSB-first over WIDTH cycles.
// Define SERIAL_SUB_OVF_EN to add the two's-complement overflow output ovf.
module serial_subtractor_ctrl
  import sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_r;
  state_t           next_state_s;
  logic             accept_s;
  logic             finish_s;
  logic [WIDTH-1:0] sa_r;
  logic [WIDTH-1:0] sb_r;
  logic [WIDTH-1:0] res_r;
  logic             borrow_r;
  logic [CNT_W-1:0] count_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] diff_r;
  logic             borrow_out_r;
  logic             d_s;
  logic             bnext_s;

  serial_sub_cell u_cell (
    .x    (sa_r[0]),
    .y    (sb_r[0]),
    .bin  (borrow_r),
    .d    (d_s),
    .bout (bnext_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic plus accept/finish strobes for the datapath.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    finish_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s = RUN;
          accept_s     = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        if (count_r == LAST_CNT) begin
          next_state_s = DONE;
          finish_s     = 1'b1;
        end else begin
          next_state_s = RUN;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Operand shifting, borrow chain, bit counter and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa_r         <= {WIDTH{1'b0}};
      sb_r         <= {WIDTH{1'b0}};
      res_r        <= {WIDTH{1'b0}};
      borrow_r     <= 1'b0;
      count_r      <= {CNT_W{1'b0}};
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      diff_r       <= {WIDTH{1'b0}};
      borrow_out_r <= 1'b0;
    end else begin
      done_r <= finish_s;
      if (accept_s) begin
        sa_r     <= a;
        sb_r     <= b;
        borrow_r <= 1'b0;
        count_r  <= {CNT_W{1'b0}};
        busy_r   <= 1'b1;
      end else if (state_r == RUN) begin
        sa_r     <= sa_r >> 1;
        sb_r     <= sb_r >> 1;
        res_r    <= {d_s, res_r[WIDTH-1:1]};
        borrow_r <= bnext_s;
        // Counter saturates at the last bit so it never exceeds WIDTH-1.
        if (finish_s) begin
          count_r      <= count_r;
          diff_r       <= {d_s, res_r[WIDTH-1:1]};
          borrow_out_r <= bnext_s;
        end else begin
          count_r <= count_r + CNT_W'(1);
        end
      end else if (state_r == DONE) begin
        busy_r <= 1'b0;
      end else begin
        busy_r <= busy_r;
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic sign_a_r;
  logic sign_b_r;
  logic ovf_r;

  // Operand sign capture and overflow flag, updated together with diff.
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_a_r <= 1'b0;
      sign_b_r <= 1'b0;
      ovf_r    <= 1'b0;
    end else if (accept_s) begin
      sign_a_r <= a[WIDTH-1];
      sign_b_r <= b[WIDTH-1];
    end else if (finish_s) begin
      ovf_r <= (sign_a_r ^ sign_b_r) & (sign_a_r ^ d_s);
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign ovf = ovf_r;
`endif

  assign busy       = busy_r;
  assign done       = done_r;
  assign diff       = diff_r;
  assign borrow_out = borrow_out_r;

endmodule
